// File: rtl/video_in_store.sv
// Drains 8-bit pixels from the capture FIFO, packs four per 32-bit word and writes
// whole frames to memory as a Wishbone B3 master using incrementing bursts.
//
// state | meaning
// IDLE  | waiting for frame_start; base address latched on acceptance
// FILL  | popping 4*BURST pixels from the FIFO into the burst buffer
// WRITE | Wishbone burst of BURST words in flight
// DONE  | frame_done pulse, then back to IDLE
module video_in_store #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int BURST  = 8
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        frame_start,
  input  logic [31:0] frame_base,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_r_e,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  input  logic        wb_ack,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int TOTAL = WIDTH * HEIGHT / 4;
  localparam int PIX   = 4 * BURST;
  localparam int PW    = $clog2(PIX + 1);
  localparam int BW    = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int WW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t      state;
  logic [31:0] base;
  logic [WW-1:0] word_cnt;
  logic [PW-1:0] rd_cnt;
  logic [PW-1:0] cap_cnt;
  logic        rd_pend;
  logic [BW-1:0] beat;
  logic [31:0] buf_mem [BURST];

  logic [BW-1:0] beat_nxt;
  logic [WW-1:0] word_nxt;
  logic [BW-1:0] cap_word;
  logic [4:0]    cap_lane;

  assign beat_nxt = beat + 1'b1;
  assign word_nxt = word_cnt + 1'b1;
  assign cap_word = cap_cnt[BW+1:2];
  assign cap_lane = {cap_cnt[1:0], 3'b000};

  // Combinational so a read never uses a stale view of fifo_empty.
  assign fifo_r_e = (state == FILL) && !fifo_empty && (rd_cnt < PW'(PIX));

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state      <= IDLE;
      base       <= '0;
      word_cnt   <= '0;
      rd_cnt     <= '0;
      cap_cnt    <= '0;
      rd_pend    <= 1'b0;
      beat       <= '0;
      wb_cyc     <= 1'b0;
      wb_stb     <= 1'b0;
      wb_we      <= 1'b0;
      wb_adr     <= '0;
      wb_dat_o   <= '0;
      wb_sel     <= '0;
      wb_cti     <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      for (int i = 0; i < BURST; i++) buf_mem[i] <= '0;
    end else begin
      frame_err  <= frame_start && (state != IDLE);
      frame_done <= 1'b0;
      rd_pend    <= fifo_r_e;
      case (state)
        IDLE: begin
          if (frame_start) begin
            base     <= frame_base & 32'hFFFF_FFFC;
            word_cnt <= '0;
            rd_cnt   <= '0;
            cap_cnt  <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (fifo_r_e) rd_cnt <= rd_cnt + 1'b1;
          if (rd_pend) begin
            buf_mem[cap_word][cap_lane +: 8] <= fifo_data;
            if (cap_cnt == PW'(PIX - 1)) begin
              cap_cnt  <= '0;
              rd_cnt   <= '0;
              beat     <= '0;
              state    <= WRITE;
              wb_cyc   <= 1'b1;
              wb_stb   <= 1'b1;
              wb_we    <= 1'b1;
              wb_sel   <= 4'hF;
              wb_adr   <= base + (32'(word_cnt) << 2);
              // With a one-word burst the final pixel lands in word 0 this same edge.
              wb_dat_o <= (BURST == 1) ? {fifo_data, buf_mem[0][23:0]} : buf_mem[0];
              wb_cti   <= (BURST == 1) ? 3'b111 : 3'b010;
            end else begin
              cap_cnt <= cap_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (wb_ack) begin
            word_cnt <= word_nxt;
            if (beat == BW'(BURST - 1)) begin
              wb_cyc   <= 1'b0;
              wb_stb   <= 1'b0;
              wb_we    <= 1'b0;
              wb_sel   <= '0;
              wb_cti   <= '0;
              wb_adr   <= '0;
              wb_dat_o <= '0;
              if (word_nxt == WW'(TOTAL)) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end else begin
                state <= FILL;
              end
            end else begin
              beat     <= beat_nxt;
              wb_adr   <= wb_adr + 32'd4;
              wb_dat_o <= buf_mem[beat_nxt];
              wb_cti   <= (beat_nxt == BW'(BURST - 1)) ? 3'b111 : 3'b010;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_in_store.sv
// Directed and randomized frames for video_in_store (8x2 pixels, 2-word bursts),
// checked against a FIFO/Wishbone-slave model and a packing reference.
module tb_video_in_store;

  localparam int W = 8, H = 2, B = 2;
  localparam int NPIX = W * H;
  localparam int NWORD = NPIX / 4;

  logic        clk = 1'b0;
  logic        nRST;
  logic        frame_start;
  logic [31:0] frame_base;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_r_e;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic        wb_ack;
  logic        frame_done, frame_err;

  video_in_store #(.WIDTH(W), .HEIGHT(H), .BURST(B)) dut (
    .clk(clk), .nRST(nRST), .frame_start(frame_start), .frame_base(frame_base),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_r_e(fifo_r_e),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_ack(wb_ack),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // stimulus/model state
  logic [7:0]  fq[$];
  logic [7:0]  pix[NPIX];
  logic [7:0]  next_data;
  bit          data_pend = 0;
  bit          nrst_drive = 0;
  bit          fs_next = 0;
  logic [31:0] fs_base = '0;
  int          gap_cnt = 0, gap_at = 0, rd_tb = 0;
  bit          gap_done = 0, gap_flag = 0;
  int          ack_mode = 0, ack_delay = 0, wait_cnt = 0;
  bit          beat_seen = 0;
  logic [31:0] hold_adr, hold_dat;
  logic [2:0]  hold_cti;
  logic [31:0] log_adr[$], log_dat[$];
  logic [2:0]  log_cti[$];
  int          done_cnt = 0, err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, let combinational outputs settle, then observe.
  task automatic step();
    @(negedge clk);
    nRST        = nrst_drive;
    frame_start = fs_next;
    frame_base  = fs_next ? fs_base : $urandom;
    fs_next     = 0;
    if (data_pend) begin fifo_data = next_data; data_pend = 0; end
    else fifo_data = 8'($urandom);
    gap_flag = 0;
    if (gap_cnt > 0) begin fifo_empty = 1; gap_flag = 1; gap_cnt--; end
    else fifo_empty = (fq.size() == 0);
    wb_ack = 0;
    if (wb_cyc && wb_stb) begin
      if (!beat_seen) begin
        beat_seen = 1; wait_cnt = 0;
        hold_adr = wb_adr; hold_dat = wb_dat_o; hold_cti = wb_cti;
        ack_delay = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
      end else begin
        chk("hold_adr", wb_adr, hold_adr);
        chk("hold_dat", wb_dat_o, hold_dat);
        chk("hold_cti", 32'(wb_cti), 32'(hold_cti));
      end
      if (wait_cnt >= ack_delay) begin
        wb_ack = 1; beat_seen = 0;
        chk("sel", 32'(wb_sel), 32'hF);
        chk("we", 32'(wb_we), 32'd1);
        log_adr.push_back(wb_adr); log_dat.push_back(wb_dat_o); log_cti.push_back(wb_cti);
      end else wait_cnt++;
    end
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    #1;
    if (gap_flag) begin
      chk("gap_rd", 32'(fifo_r_e), 32'd0);
      chk("gap_cyc", 32'(wb_cyc), 32'd0);
    end
    if (wb_cyc) chk("rd_in_write", 32'(fifo_r_e), 32'd0);
    if (fifo_r_e) begin
      next_data = fq.pop_front(); data_pend = 1; rd_tb++;
      if (gap_at > 0 && !gap_done && rd_tb == gap_at) begin gap_cnt = 5; gap_done = 1; end
    end
  endtask

  task automatic run_frame(input logic [31:0] base, input bit seq, input int amode,
                           input int gap, input bit inj_err);
    int cyc;
    bit injected;
    logic [31:0] ea, ed;
    for (int i = 0; i < NPIX; i++) pix[i] = seq ? 8'(i) : 8'($urandom);
    for (int i = 0; i < NPIX; i++) fq.push_back(pix[i]);
    log_adr.delete(); log_dat.delete(); log_cti.delete();
    done_cnt = 0; err_cnt = 0; rd_tb = 0; gap_at = gap; gap_done = 0;
    ack_mode = amode; beat_seen = 0; injected = 0;
    fs_next = 1; fs_base = base;
    cyc = 0;
    while (done_cnt == 0 && cyc < 400) begin
      step();
      cyc++;
      if (inj_err && !injected && wb_stb) begin
        fs_next = 1; fs_base = 32'h0000_5000; injected = 1;
      end
    end
    chk("frame_done_seen", 32'(done_cnt != 0), 32'd1);
    repeat (3) step();
    chk("frame_done_cnt", 32'(done_cnt), 32'd1);
    chk("frame_err_cnt", 32'(err_cnt), inj_err ? 32'd1 : 32'd0);
    chk("beats", 32'(log_adr.size()), 32'(NWORD));
    chk("fifo_drained", 32'(fq.size()), 32'd0);
    for (int w = 0; w < NWORD && w < log_adr.size(); w++) begin
      ea = (base & 32'hFFFF_FFFC) + 32'(4 * w);
      ed = {pix[4*w+3], pix[4*w+2], pix[4*w+1], pix[4*w]};
      chk("adr", log_adr[w], ea);
      chk("dat", log_dat[w], ed);
      chk("cti", 32'(log_cti[w]), (w % B == B - 1) ? 32'd7 : 32'd2);
    end
  endtask

  initial begin
    int cyc;
    nRST = 0; frame_start = 0; frame_base = '0; fifo_empty = 1; fifo_data = '0; wb_ack = 0;
    nrst_drive = 0;
    repeat (2) step();
    chk("rst_cyc", 32'(wb_cyc), 0);
    chk("rst_stb", 32'(wb_stb), 0);
    chk("rst_adr", wb_adr, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_rd", 32'(fifo_r_e), 0);
    chk("rst_done", 32'(frame_done), 0);
    nrst_drive = 1;
    repeat (2) step();

    run_frame(32'h0000_1000, 1, 0, 0, 0);
    run_frame(32'h0000_1000, 1, 3, 0, 0);
    run_frame(32'h0000_1000, 1, 0, 4, 0);
    run_frame(32'h0000_1000, 1, 0, 0, 1);

    // reset in the middle of the first burst
    for (int i = 0; i < NPIX; i++) fq.push_back(8'(i));
    fs_next = 1; fs_base = 32'h0000_1000; ack_mode = 2; gap_at = 0; rd_tb = 0;
    cyc = 0;
    while (!wb_cyc && cyc < 100) begin step(); cyc++; end
    chk("reach_burst", 32'(wb_cyc), 32'd1);
    nrst_drive = 0; step();
    nrst_drive = 1; step();
    chk("post_rst_cyc", 32'(wb_cyc), 32'd0);
    chk("post_rst_stb", 32'(wb_stb), 32'd0);
    chk("post_rst_rd", 32'(fifo_r_e), 32'd0);
    fq.delete(); data_pend = 0; beat_seen = 0;
    step();
    run_frame(32'h0000_2000, 1, 0, 0, 0);

    run_frame(32'hFFFF_FFF8, 1, 1, 0, 0);

    for (int k = 0; k < 4; k++)
      run_frame($urandom, 0, -1, int'($urandom_range(0, 12)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
